// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants up to NUM_PORTS of NUM_REQ functional-unit results per cycle.
// Define CDB_ARB_OUTREG_EN for a registered cdb_o; otherwise cdb_o is combinational from the grant.
module cdb_arbiter #(
  parameter int unsigned NUM_FU    = 4,
  parameter int unsigned NUM_REQ   = NUM_FU,
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned CDB_WIDTH = 38
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [NUM_REQ-1:0]                   fu_valid_i,
  input  logic [NUM_REQ-1:0][CDB_WIDTH-1:0]    fu_cdb_i,
  output logic [NUM_REQ-1:0]                   fu_ready_o,
  input  logic                                 flush_i,
  output logic [NUM_PORTS-1:0][CDB_WIDTH-1:0]  cdb_o
);

  localparam int unsigned PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // CDB_t places its valid flag in the most significant bit.
  localparam int unsigned VALID_BIT = CDB_WIDTH - 1;

  logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]                 grant;
  logic [NUM_PORTS-1:0][CDB_WIDTH-1:0] cdb_d;
  int unsigned                        gnt_cnt;
  int unsigned                        scan_idx;
  int unsigned                        last_idx;

  // Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ); the k-th hit lands on port k.
  always_comb begin
    grant    = '0;
    cdb_d    = '0;
    rr_ptr_d = rr_ptr_q;
    gnt_cnt  = 0;
    scan_idx = 0;
    last_idx = 0;
    if (!reset_i && !flush_i) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_idx = 32'(rr_ptr_q) + k;
        if (scan_idx >= NUM_REQ) begin
          scan_idx = scan_idx - NUM_REQ;
        end
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
          if (r == scan_idx && fu_valid_i[r] && gnt_cnt < NUM_PORTS) begin
            grant[r] = 1'b1;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
              if (p == gnt_cnt) begin
                cdb_d[p]            = fu_cdb_i[r];
                cdb_d[p][VALID_BIT] = 1'b1;
              end
            end
            gnt_cnt  = gnt_cnt + 1;
            last_idx = r;
          end
        end
      end
      if (gnt_cnt != 0) begin
        rr_ptr_d = (last_idx + 1 == NUM_REQ) ? '0 : PTR_W'(last_idx + 1);
      end
    end
    if (flush_i) begin
      rr_ptr_d = '0;
    end
  end

  assign fu_ready_o = grant;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef CDB_ARB_OUTREG_EN
  logic [NUM_PORTS-1:0][CDB_WIDTH-1:0] cdb_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cdb_q <= '0;
    end else begin
      cdb_q <= cdb_d;
    end
  end

  assign cdb_o = cdb_q;
`else
  assign cdb_o = cdb_d;
`endif

`ifndef SYNTHESIS
  a_ready_needs_valid: assert property (@(posedge clk_i) (fu_ready_o & ~fu_valid_i) == '0);
  a_grant_limit:       assert property (@(posedge clk_i) $countones(fu_ready_o) <= NUM_PORTS);
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter (NUM_REQ=4, NUM_PORTS=2); works in registered and bypass builds.
module tb_cdb_arbiter;
  localparam int NR = 4;
  localparam int NP = 2;
  localparam int W  = 38;
`ifdef CDB_ARB_OUTREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    flush;
  logic [NR-1:0]           valid;
  logic [NR-1:0]           ready;
  logic [NR-1:0][W-1:0]    fu_cdb;
  logic [NP-1:0][W-1:0]    cdb;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int            cyc;
    int            port;
    logic [W-1:0]  data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  cdb_arbiter #(
    .NUM_REQ   (NR),
    .NUM_PORTS (NP),
    .CDB_WIDTH (W)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .fu_valid_i (valid),
    .fu_cdb_i   (fu_cdb),
    .fu_ready_o (ready),
    .flush_i    (flush),
    .cdb_o      (cdb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] mk(int r, logic vb);
    logic [4:0] rd;
    rd = (r == 0) ? 5'd7 : (r == 1) ? 5'd2 : (r == 2) ? 5'd5 : 5'd1;
    return {vb, rd, 32'hC0DE_0000 + 32'(r)};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid broadcast slot must match the head of the scoreboard.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int p = 0; p < NP; p++) begin
        if (cdb[p][W-1]) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cdb_unexpected: port %0d got %0h expected nothing (cycle %0d)", p, cdb[p], cyc);
          end else begin
            mon_e = sb.pop_front();
            check("cdb_cycle", 64'(cyc), 64'(mon_e.cyc));
            check("cdb_port", 64'(p), 64'(mon_e.port));
            check("cdb_data", 64'(cdb[p]), 64'(mon_e.data));
          end
        end
      end
    end
  end

  // Called at posedge+1: drive a vector, check grants, queue expected broadcasts, check next pointer.
  task automatic apply(string name, logic [3:0] v, logic f, logic [3:0] exp_rdy,
                       int p0, int p1, int exp_ptr);
    exp_t e;
    valid = v;
    flush = f;
    #1;
    check({name, "_ready"}, 64'(ready), 64'(exp_rdy));
    if (p0 >= 0) begin
      e.cyc = cyc + LAT; e.port = 0; e.data = mk(p0, 1'b1);
      sb.push_back(e);
    end
    if (p1 >= 0) begin
      e.cyc = cyc + LAT; e.port = 1; e.data = mk(p1, 1'b1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check({name, "_ptr"}, 64'(dut.rr_ptr_q), 64'(exp_ptr));
  endtask

  initial begin
    for (int r = 0; r < NR; r++) fu_cdb[r] = mk(r, r[0]);
    reset = 1'b1;
    flush = 1'b0;
    valid = 4'b1111;

    @(posedge clk); #1;
    check("reset1_ready", 64'(ready), 64'd0);
    @(posedge clk); #1;
    check("reset2_ready", 64'(ready), 64'd0);
    check("reset_cdb_valid", 64'({cdb[1][W-1], cdb[0][W-1]}), 64'd0);
    check("reset_ptr", 64'(dut.rr_ptr_q), 64'd0);
    reset = 1'b0;

    //     name         valid    fl  ready    p0  p1  ptr
    apply("full_a",    4'b1111, 0, 4'b0011,  0,  1, 2);
    apply("full_b",    4'b1111, 0, 4'b1100,  2,  3, 0);
    apply("full_c",    4'b1111, 0, 4'b0011,  0,  1, 2);
    apply("sparse",    4'b0100, 0, 4'b0100,  2, -1, 3);
    apply("wrap",      4'b1001, 0, 4'b1001,  3,  0, 1);
    apply("flush",     4'b1111, 1, 4'b0000, -1, -1, 0);
    apply("post_fl",   4'b1111, 0, 4'b0011,  0,  1, 2);
    apply("idle",      4'b0000, 0, 4'b0000, -1, -1, 2);
    apply("single1",   4'b0010, 0, 4'b0010,  1, -1, 2);
    apply("skip3",     4'b0111, 0, 4'b0101,  2,  0, 1);
    apply("mid",       4'b1110, 0, 4'b0110,  1,  2, 3);
    apply("wrap13",    4'b1010, 0, 4'b1010,  3,  1, 2);
    apply("wrap0",     4'b0001, 0, 4'b0001,  0, -1, 1);
    apply("flush_idl", 4'b0000, 1, 4'b0000, -1, -1, 0);
    apply("pre_rst",   4'b1111, 0, 4'b0011,  0,  1, 2);

    reset = 1'b1;
    valid = 4'b1111;
    #1;
    check("midrst_ready", 64'(ready), 64'd0);
    @(posedge clk); #1;
    check("midrst_ptr", 64'(dut.rr_ptr_q), 64'd0);
    reset = 1'b0;

    apply("post_rst",  4'b1111, 0, 4'b0011,  0,  1, 2);
    apply("drain1",    4'b0000, 0, 4'b0000, -1, -1, 2);
    apply("drain2",    4'b0000, 0, 4'b0000, -1, -1, 2);

    @(negedge clk); #1;
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
